// File: rtl/fp_add_arb.sv
// fp_add_arb: round-robin scheduler sharing one pipelined FP adder among
// NUM_REQ requesters. Each issued operand pair is tagged with its requester
// index in a shadow pipeline of LATENCY stages, so every returned sum can be
// steered back to the requester that issued it.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   en                : grant enable; in-flight operations complete regardless
//   req_vld/req_rdy   : per-requester handshake (req_rdy is the grant)
//   req_a, req_b      : packed operand pairs, requester i at [32i+31:32i]
//   add_in_vld/a/b    : registered issue to the adder
//   add_sum_vld/sum   : result from the adder, LATENCY cycles after issue
//   res_vld, res_sum  : one-hot result strobe and shared result data
//   busy              : issue register or any tag stage holds an operation
//   seq_err           : sticky; adder result and tag pipeline disagreed
//
// Handshake: a pair is transferred on a rising edge where req_vld[i] and
// req_rdy[i] are both high. req_rdy is combinational from req_vld, ptr and en
// only, is at most one-hot, and the requester may hold req_vld high to
// present a fresh pair every cycle. Results have no backpressure.
module fp_add_arb #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 8,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [NUM_REQ-1:0]     req_vld,
   output logic [NUM_REQ-1:0]     req_rdy,
   input  logic [NUM_REQ*32-1:0]  req_a,
   input  logic [NUM_REQ*32-1:0]  req_b,
   output logic                   add_in_vld,
   output logic [31:0]            add_a,
   output logic [31:0]            add_b,
   input  logic                   add_sum_vld,
   input  logic [31:0]            add_sum,
   output logic [NUM_REQ-1:0]     res_vld,
   output logic [31:0]            res_sum,
   output logic                   busy,
   output logic                   seq_err
);

   localparam logic [IDW:0]   NR_W    = (IDW+1)'(NUM_REQ);
   localparam logic [IDW-1:0] NR_LAST = IDW'(NUM_REQ-1);

   logic [IDW-1:0]     ptr;
   logic [2*NUM_REQ-1:0] vld2;
   logic [NUM_REQ-1:0] rot;
   logic               gnt_any;
   logic [IDW-1:0]     gnt_off;
   logic [IDW:0]       gnt_sum;
   logic [IDW-1:0]     gnt_id;
   logic [31:0]        sel_a;
   logic [31:0]        sel_b;
   logic [IDW-1:0]     iss_id;
   logic [LATENCY-1:0] tag_vld;
   logic [IDW-1:0]     tag_id [LATENCY];
   logic               tail_vld;
   logic [IDW-1:0]     tail_id;

   // Rotate the request vector so bit k is requester (ptr+k) mod NUM_REQ;
   // the lowest set bit is then the round-robin winner.
   assign vld2 = {req_vld, req_vld} >> ptr;
   assign rot  = vld2[NUM_REQ-1:0];

   always_comb begin
      gnt_any = 1'b0;
      gnt_off = '0;
      // Scan downward so the lowest offset is the one left standing.
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (en && rot[k]) begin
            gnt_any = 1'b1;
            gnt_off = IDW'(k);
         end
      end
      gnt_sum = {1'b0, ptr} + {1'b0, gnt_off};
      if (gnt_sum >= NR_W) begin
         gnt_sum = gnt_sum - NR_W;
      end
      gnt_id = gnt_sum[IDW-1:0];
   end

   always_comb begin
      req_rdy = '0;
      sel_a   = '0;
      sel_b   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_id == IDW'(i)) begin
            req_rdy[i] = gnt_any;
            sel_a      = req_a[i*32 +: 32];
            sel_b      = req_b[i*32 +: 32];
         end
      end
   end

   // Issue register; operands hold their last value when nothing is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         add_in_vld <= 1'b0;
         add_a      <= '0;
         add_b      <= '0;
         iss_id     <= '0;
      end else begin
         add_in_vld <= gnt_any;
         if (gnt_any) begin
            ptr    <= (gnt_id == NR_LAST) ? '0 : gnt_id + IDW'(1);
            add_a  <= sel_a;
            add_b  <= sel_b;
            iss_id <= gnt_id;
         end
      end
   end

   // Tag pipeline: stage 0 captures on the same edge the adder samples its
   // operands, so the tail stage lines up with add_sum_vld.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            tag_id[s] <= '0;
         end
      end else begin
         tag_vld[0] <= add_in_vld;
         tag_id[0]  <= iss_id;
         for (int s = 1; s < LATENCY; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_id[s]  <= tag_id[s-1];
         end
      end
   end

   assign tail_vld = tag_vld[LATENCY-1];
   assign tail_id  = tag_id[LATENCY-1];

   // Return stage: deliver only when tag and adder agree; any disagreement
   // is a sequencing fault that latches until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_vld <= '0;
         res_sum <= '0;
         seq_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            res_vld[i] <= tail_vld && add_sum_vld && (tail_id == IDW'(i));
         end
         if (tail_vld && add_sum_vld) begin
            res_sum <= add_sum;
         end
         if (tail_vld != add_sum_vld) begin
            seq_err <= 1'b1;
         end
      end
   end

   assign busy = add_in_vld | (|tag_vld);

endmodule

// File: tb/tb_fp_add_arb.sv
// tb_fp_add_arb: directed bench for fp_add_arb with a behavioural adder
// model. Drivers push expected issues and results into queues; monitors pop
// and compare whenever the DUT presents an issue or a result.
module tb_fp_add_arb;

   localparam int NR  = 4;
   localparam int LAT = 8;
   localparam int EW  = 68;  // {due cycle[31:0], one-hot[3:0], sum[31:0]}
   localparam int IW  = 96;  // {due cycle[31:0], a[31:0], b[31:0]}

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            en = 1'b0;
   logic [NR-1:0]   req_vld = '0;
   logic [NR-1:0]   req_rdy;
   logic [NR*32-1:0] req_a = '0;
   logic [NR*32-1:0] req_b = '0;
   logic            add_in_vld;
   logic [31:0]     add_a;
   logic [31:0]     add_b;
   logic            add_sum_vld;
   logic [31:0]     add_sum;
   logic [NR-1:0]   res_vld;
   logic [31:0]     res_sum;
   logic            busy;
   logic            seq_err;
   logic            inj = 1'b0;

   int              cyc = 0;
   int              checks = 0;
   int              errors = 0;
   logic [EW-1:0]   exp_q[$];
   logic [IW-1:0]   iss_q[$];

   fp_add_arb #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
      .add_in_vld(add_in_vld), .add_a(add_a), .add_b(add_b),
      .add_sum_vld(add_sum_vld), .add_sum(add_sum),
      .res_vld(res_vld), .res_sum(res_sum), .busy(busy), .seq_err(seq_err)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- hand-computed vectors ----------------
   function automatic logic [31:0] va(input int i);
      case (i)
         0: return 32'h3F800000;  // 1.0
         1: return 32'h40000000;  // 2.0
         2: return 32'h3FC00000;  // 1.5
         3: return 32'h40400000;  // 3.0
         4: return 32'h40A00000;  // 5.0
         5: return 32'h3F000000;  // 0.5
         6: return 32'h41200000;  // 10.0
         default: return 32'hC0000000;  // -2.0
      endcase
   endfunction

   function automatic logic [31:0] vb(input int i);
      case (i)
         0: return 32'h40000000;  // 2.0
         1: return 32'h40000000;  // 2.0
         2: return 32'h3FC00000;  // 1.5
         3: return 32'h3F800000;  // 1.0
         4: return 32'h40400000;  // 3.0
         5: return 32'h3F000000;  // 0.5
         6: return 32'h40A00000;  // 5.0
         default: return 32'h40400000;  // 3.0
      endcase
   endfunction

   function automatic logic [31:0] vs(input int i);
      case (i)
         0: return 32'h40400000;  // 3.0
         1: return 32'h40800000;  // 4.0
         2: return 32'h40400000;  // 3.0
         3: return 32'h40800000;  // 4.0
         4: return 32'h41000000;  // 8.0
         5: return 32'h3F800000;  // 1.0
         6: return 32'h41700000;  // 15.0
         default: return 32'h3F800000;  // 1.0
      endcase
   endfunction

   // ---------------- adder model (table lookup, LAT stages) ----------------
   function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 8; i++) begin
         if (va(i) == a && vb(i) == b) return vs(i);
      end
      return 32'hDEADBEEF;
   endfunction

   logic [32:0] apipe [LAT];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) apipe[i] <= '0;
      end else begin
         apipe[0] <= {add_in_vld, model_sum(add_a, add_b)};
         for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
      end
   end

   assign add_sum_vld = apipe[LAT-1][32] | inj;
   assign add_sum     = apipe[LAT-1][31:0];

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] e;
      while (exp_q.size() != 0 && int'(exp_q[0][67:36]) < cyc) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL res_missing: got none expected res_vld=%b sum=%h at cycle %0d",
                  e[35:32], e[31:0], e[67:36]);
      end
      if (res_vld != '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected: got res_vld=%b sum=%h expected none (cycle %0d)",
                     res_vld, res_sum, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("res_cycle", cyc, e[67:36]);
            chk("res_vld", 32'(res_vld), 32'(e[35:32]));
            chk("res_sum", res_sum, e[31:0]);
         end
      end
   end

   always @(negedge clk) begin
      logic [IW-1:0] e;
      while (iss_q.size() != 0 && int'(iss_q[0][95:64]) < cyc) begin
         e = iss_q.pop_front();
         checks++;
         errors++;
         $display("FAIL issue_missing: got none expected a=%h b=%h at cycle %0d",
                  e[63:32], e[31:0], e[95:64]);
      end
      if (add_in_vld) begin
         if (iss_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got a=%h b=%h expected none (cycle %0d)",
                     add_a, add_b, cyc);
         end else begin
            e = iss_q.pop_front();
            chk("issue_cycle", cyc, e[95:64]);
            chk("add_a", add_a, e[63:32]);
            chk("add_b", add_b, e[31:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One cycle of stimulus. vecs holds a 3-bit vector index per requester.
   // exp_g < 0 means no grant expected; exp_busy < 0 means busy unchecked.
   task automatic present(input logic [NR-1:0] vld, input logic [11:0] vecs,
                          input logic e, input int exp_g, input int exp_busy);
      int gv;
      req_vld = vld;
      en      = e;
      req_a   = '0;
      req_b   = '0;
      for (int i = 0; i < NR; i++) begin
         gv    = int'((vecs >> (3*i)) & 12'h7);
         req_a = req_a | (128'(va(gv)) << (32*i));
         req_b = req_b | (128'(vb(gv)) << (32*i));
      end
      @(negedge clk);
      chk("req_rdy", 32'(req_rdy), (exp_g < 0) ? 32'd0 : 32'(1 << exp_g));
      if (exp_busy >= 0) chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_g >= 0) begin
         gv = int'((vecs >> (3*exp_g)) & 12'h7);
         iss_q.push_back({32'(cyc + 1), va(gv), vb(gv)});
         exp_q.push_back({32'(cyc + LAT + 2), 4'(1 << exp_g), vs(gv)});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req_vld = '0;
      en      = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      req_vld = '0;
      en      = 1'b1;
      while ((exp_q.size() != 0 || iss_q.size() != 0 || busy) && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 60) begin
         errors++;
         $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
      end
      idle(2);
   endtask

   task automatic do_reset();
      req_vld = '0;
      en      = 1'b1;
      inj     = 1'b0;
      exp_q.delete();
      iss_q.delete();
      rst_n   = 1'b0;
      #1;
      chk("rst_add_in_vld", 32'(add_in_vld), 32'd0);
      chk("rst_add_a", add_a, 32'd0);
      chk("rst_add_b", add_b, 32'd0);
      chk("rst_res_vld", 32'(res_vld), 32'd0);
      chk("rst_res_sum", res_sum, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_seq_err", 32'(seq_err), 32'd0);
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      #1;
      do_reset();

      // Single request from requester 2, then all valid proves ptr moved to 3.
      present(4'b0100, 12'h000, 1'b1, 2, 0);
      present(4'b1111, 12'h000, 1'b1, 3, 1);
      drain();

      // Full contention from reset: grants 0,1,2,3,0,1,2,3 back to back.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         present(4'b1111, {3'(k+3), 3'(k+2), 3'(k+1), 3'(k)}, 1'b1, k % 4, -1);
      end
      drain();
      chk("contention_seq_err", 32'(seq_err), 32'd0);

      // Skip idle requesters: move ptr to 1, then only 0 and 3 valid.
      present(4'b0001, 12'h004, 1'b1, 0, -1);
      present(4'b1001, 12'h186, 1'b1, 3, -1);
      present(4'b1001, 12'h1C5, 1'b1, 0, -1);
      present(4'b1001, 12'h003, 1'b1, 3, -1);
      drain();

      // en gating: one issue, then en low; busy drops 10 cycles after handshake.
      do_reset();
      present(4'b0001, 12'h005, 1'b1, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         present(4'b1111, 12'h000, 1'b0, -1, (k <= 9) ? 1 : 0);
      end
      drain();

      // Ordering on requester 1: 2.0+2.0 then 1.5+1.5.
      present(4'b0010, 12'h008, 1'b1, 1, -1);
      present(4'b0010, 12'h010, 1'b1, 1, -1);
      drain();

      // Reset mid-flight: three issues, reset 5 cycles later, nothing returns.
      present(4'b0111, 12'h0D1, 1'b1, 2, -1);
      present(4'b0111, 12'h0D1, 1'b1, 0, -1);
      present(4'b0111, 12'h0D1, 1'b1, 1, -1);
      idle(5);
      do_reset();
      idle(15);
      chk("midflight_seq_err", 32'(seq_err), 32'd0);

      // Fault injection: result strobe with no tag sets sticky seq_err.
      inj = 1'b1;
      @(negedge clk);
      chk("inj_seq_err_same", 32'(seq_err), 32'd0);
      @(posedge clk);
      #1;
      inj = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("inj_seq_err_sticky", 32'(seq_err), 32'd1);
      end
      @(posedge clk);
      #1;
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_add_arb.md
# fp_add_arb

Round-robin scheduler that shares one pipelined single-precision FP adder among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the adder. It tags each issue with the requester index in a shadow pipeline matched to the adder latency, and steers each returned sum back to the requester that issued it. It sits between the compute clients and the `fp_add` instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `LATENCY`, default 8: adder latency, in_vld to sum_vld, in cycles; must equal the attached adder.
- `IDW`, default $clog2(NUM_REQ): requester index width (derived).
- `clk` in 1: clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: when low, no new grants are made; in-flight operations still complete.
- `req_vld` in NUM_REQ: requester i has an operand pair pending.
- `req_rdy` out NUM_REQ: grant. A pair is accepted when `req_vld[i] && req_rdy[i]`.
- `req_a`, `req_b` in NUM_REQ*32: operand pairs. Requester i uses bits [32i+31:32i].
- `add_in_vld` out 1: issue strobe to the adder (registered).
- `add_a`, `add_b` out 32: operands to the adder (registered).
- `add_sum_vld` in 1: result strobe from the adder.
- `add_sum` in 32: result from the adder.
- `res_vld` out NUM_REQ: one-hot, one-cycle result strobe to the owning requester.
- `res_sum` out 32: result data, shared by all requesters. Valid when any `res_vld` bit is high.
- `busy` out 1: an issue register or any tag stage is valid.
- `seq_err` out 1: sticky. An adder result arrived with no matching tag, or a tag expired with no result.

## Operation
- **Arbitration**
  - Round-robin pointer `ptr` (IDW bits).
  - Grant goes to the lowest index i at or after `ptr` (modulo NUM_REQ) with `req_vld[i]`, only when `en`.
  - `req_rdy` is combinational from `req_vld`, `ptr` and `en`, and is at most one-hot.
  - `req_rdy[i]` must not depend on `req_rdy` from the same cycle.
  - On an accepted handshake, `ptr` <= granted index + 1, wrapping NUM_REQ-1 to 0. With no handshake, `ptr` holds.
- **Issue**
  - On handshake, next cycle: `add_in_vld`=1, `add_a`/`add_b` = the granted pair.
  - With no handshake, `add_in_vld`=0 and `add_a`/`add_b` hold their last value.
- **Tag pipeline**
  - LATENCY-stage shift register of {valid, id}.
  - Stage 0 loads {add_in_vld, issued id} in the same cycle the adder samples the operands.
  - The tail stage aligns with `add_sum_vld`.
- **Return**
  - Tail valid and `add_sum_vld`: next cycle `res_vld[id]`=1 and `res_sum`=`add_sum`.
  - Exactly one of tail valid or `add_sum_vld` high: no `res_vld`, `seq_err` <= 1.
  - `res_sum` holds between results.
- **Reset**
  - `ptr`=0, all tag valids 0, `add_in_vld`=0, `add_a`=`add_b`=0, `res_vld`=0, `res_sum`=0, `seq_err`=0.
  - Reset mid-operation discards every in-flight tag, so in-flight results are never delivered.
  - The integrator resets the adder together with this block; otherwise `seq_err` fires.
- **`en` deasserted mid-stream:** `req_rdy`=0 from that cycle; outstanding results still return; `busy` falls LATENCY+1 cycles after the last issue.

## Timing
- Throughput: one issue per cycle, sustained, with no bubbles between different requesters.
- Handshake at cycle T:
  - `add_in_vld` at T+1.
  - `add_sum_vld` at T+1+LATENCY.
  - `res_vld` at T+2+LATENCY (10 cycles at the default LATENCY).
- Results return in issue order. Per requester, result order equals handshake order.
- A requester may hold `req_vld` high; each grant consumes one pair and the next pair must be presented the following cycle.
- There is no result backpressure: requesters must accept `res_vld` unconditionally.

## Test plan
- **Single request:** requester 2 presents 0x3F800000 + 0x40000000 at cycle 0, `en`=1 → `req_rdy`=0b0100 at cycle 0; `res_vld`=0b0100 and `res_sum`=0x40400000 at cycle 10; `ptr`=3 afterwards.
- **Full contention and wrap:** all four `req_vld` held high for 8 cycles from reset → grants 0,1,2,3,0,1,2,3 on consecutive cycles; `res_vld` sequence 0b0001, 0b0010, 0b0100, 0b1000, … in cycles 10–17; `seq_err` stays 0.
- **Skip idle requesters:** `ptr`=1, only requesters 0 and 3 valid → grant 3, then 0, then 3.
- **`en` gating:** `en`=0 one cycle after the first of three issues → exactly one result at cycle 10; `busy` falls at cycle 10; `req_rdy` stays 0 while `en`=0.
- **Ordering:** requester 1 issues 2.0+2.0, then 1.5+1.5 → `res_sum` 0x40800000, then 0x40400000, on consecutive `res_vld[1]` pulses.
- **Reset mid-flight:** `rst_n` low 5 cycles after 3 issues (adder reset too) → all outputs at reset values immediately; no `res_vld` afterwards; `seq_err`=0.
- **Fault injection:** force `add_sum_vld` high with no tag pending → `seq_err`=1 next cycle and it stays 1 until reset.
